// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   state_t      - responder FSM states (IDLE, WAIT, RESP)
//   F3_*         - RISC-V load/store funct3 encodings
//   width consts - data width, byte width and wait-counter width
package dmem_pkg;

    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_BYTE_W = 8;
    localparam int DMEM_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane logic for the responder.
// Merges store data into the old word and extracts/extends load data.
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned half/word accesses are
// rejected; without it the low address bits are simply ignored for them.
// Ports:
//   is_store  in   1 = store (merge), 0 = load (extract)
//   funct3    in   RISC-V load/store width/extension code
//   addr_lo   in   byte address bits [1:0]
//   old_word  in   current contents of the addressed word
//   wdata     in   right-justified store data
//   new_word  out  word to write back (old_word on error)
//   rdata     out  extended load result (0 on error or store)
//   err       out  access is illegal
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic                   is_store,
    input  logic [2:0]             funct3,
    input  logic [1:0]             addr_lo,
    input  logic [DMEM_DATA_W-1:0] old_word,
    input  logic [DMEM_DATA_W-1:0] wdata,
    output logic [DMEM_DATA_W-1:0] new_word,
    output logic [DMEM_DATA_W-1:0] rdata,
    output logic                   err
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        misaligned;

    // Half accesses use only addr_lo[1] and word accesses ignore addr_lo,
    // which is what masks misaligned low bits when the check is disabled.
    always_comb begin
        ld_byte    = old_word[{addr_lo, 3'b000} +: 8];
        ld_half    = old_word[{addr_lo[1], 4'b0000} +: 16];
        misaligned = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        case (funct3)
            F3_H, F3_HU: misaligned = addr_lo[0];
            F3_W:        misaligned = |addr_lo;
            default:     misaligned = 1'b0;
        endcase
`endif
    end

    always_comb begin
        new_word = old_word;
        rdata    = '0;
        err      = 1'b0;
        case (funct3)
            F3_B: begin
                if (is_store) new_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
                else          rdata = {{24{ld_byte[7]}}, ld_byte};
            end
            F3_H: begin
                if (is_store) new_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
                else          rdata = {{16{ld_half[15]}}, ld_half};
            end
            F3_W: begin
                if (is_store) new_word = wdata;
                else          rdata = old_word;
            end
            F3_BU: begin
                if (is_store) err = 1'b1;
                else          rdata = {24'd0, ld_byte};
            end
            F3_HU: begin
                if (is_store) err = 1'b1;
                else          rdata = {16'd0, ld_half};
            end
            default: err = 1'b1;
        endcase
        if (misaligned) err = 1'b1;
        // A rejected access must neither change memory nor return data.
        if (err) begin
            new_word = old_word;
            rdata    = '0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder on the core load/store port.
// One outstanding access; response WAIT_STATES+1 cycles after accept.
// Optional macro DMEM_ALIGN_CHECK_EN enables misalignment errors.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_we, req_addr,
//   req_funct3, req_wdata      request fields, captured at accept
//   rsp_valid, rsp_rdata,
//   rsp_err                    one-cycle response strobe and payload
//   wr, rd, addr,
//   wr_data, rd_data           monitor bus for completed accesses
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              wr,
    output logic              rd,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    localparam int WORDS = 2 ** (ADDR_W - 2);
    localparam logic [DMEM_CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? DMEM_CNT_W'(WAIT_STATES - 1) : '0;

    state_t                state;
    state_t                state_next;
    logic [DMEM_CNT_W-1:0] wait_cnt;

    logic                  cap_we;
    logic [ADDR_W-1:0]     cap_addr;
    logic [2:0]            cap_funct3;
    logic [DATA_W-1:0]     cap_wdata;

    logic [DATA_W-1:0]     mem [WORDS];
    logic [DATA_W-1:0]     mem_word;
    logic [DATA_W-1:0]     lane_new_word;
    logic [DATA_W-1:0]     lane_rdata;
    logic                  lane_err;

    logic [ADDR_W-1:0]     mon_addr_q;
    logic [DATA_W-1:0]     mon_wdata_q;
    logic [DATA_W-1:0]     mon_rdata_q;

    assign mem_word = mem[cap_addr[ADDR_W-1:2]];

    dmem_lane_align u_lane (
        .is_store (cap_we),
        .funct3   (cap_funct3),
        .addr_lo  (cap_addr[1:0]),
        .old_word (mem_word),
        .wdata    (cap_wdata),
        .new_word (lane_new_word),
        .rdata    (lane_rdata),
        .err      (lane_err)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_valid) state_next = (WAIT_STATES > 0) ? WAIT : RESP;
            WAIT: if (wait_cnt == '0) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request fields are frozen at accept so inputs changing during WAIT
    // cannot disturb the access in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt   <= '0;
            cap_we     <= 1'b0;
            cap_addr   <= '0;
            cap_funct3 <= '0;
            cap_wdata  <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                wait_cnt   <= WAIT_LOAD;
                cap_we     <= req_we;
                cap_addr   <= req_addr;
                cap_funct3 <= req_funct3;
                cap_wdata  <= req_wdata;
            end else if (state == WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        rsp_err   = rsp_valid && lane_err;
        rsp_rdata = (rsp_valid && !cap_we) ? lane_rdata : '0;
        wr        = rsp_valid && !lane_err && cap_we;
        rd        = rsp_valid && !lane_err && !cap_we;
        addr      = (wr || rd) ? cap_addr : mon_addr_q;
        wr_data   = wr ? cap_wdata : mon_wdata_q;
        rd_data   = rd ? lane_rdata : mon_rdata_q;
    end

    // The store commits on the RESP->IDLE edge; gating with reset drops a
    // pending write when reset lands while the access is still in flight.
    always_ff @(posedge clk) begin
        if (reset && wr) mem[cap_addr[ADDR_W-1:2]] <= lane_new_word;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mon_addr_q  <= '0;
            mon_wdata_q <= '0;
            mon_rdata_q <= '0;
        end else begin
            if (wr || rd) mon_addr_q <= cap_addr;
            if (wr)       mon_wdata_q <= cap_wdata;
            if (rd)       mon_rdata_q <= lane_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder.
// Three instances with WAIT_STATES = 0, 3 and 2 share one clock.
// Honours DMEM_ALIGN_CHECK_EN for the misaligned-word expectation.
module tb_dmem_responder;

    logic        clk;
    logic [2:0]  reset;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [2:0]  req_we;
    logic [8:0]  req_addr   [3];
    logic [2:0]  req_funct3 [3];
    logic [31:0] req_wdata  [3];
    logic [2:0]  rsp_valid;
    logic [31:0] rsp_rdata  [3];
    logic [2:0]  rsp_err;
    logic [2:0]  wr;
    logic [2:0]  rd;
    logic [8:0]  addr       [3];
    logic [31:0] wr_data    [3];
    logic [31:0] rd_data    [3];

    int compared   = 0;
    int mismatched = 0;

    logic        r_seen;
    int          r_lat;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_wr;
    logic        r_rd;
    logic [8:0]  r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rddata;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .DATA_W      (32),
            .ADDR_W      (9),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 3 : 2))
        ) u_dut (
            .clk        (clk),
            .reset      (reset[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_we     (req_we[g]),
            .req_addr   (req_addr[g]),
            .req_funct3 (req_funct3[g]),
            .req_wdata  (req_wdata[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_rdata  (rsp_rdata[g]),
            .rsp_err    (rsp_err[g]),
            .wr         (wr[g]),
            .rd         (rd[g]),
            .addr       (addr[g]),
            .wr_data    (wr_data[g]),
            .rd_data    (rd_data[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Issues one request on instance i and waits (bounded) for its response,
    // recording the response and monitor fields plus latency in cycles.
    task automatic access(input int i, input logic we, input logic [8:0] a,
                          input logic [2:0] f3, input logic [31:0] wd);
        int n;
        @(negedge clk);
        req_valid[i]  = 1'b1;
        req_we[i]     = we;
        req_addr[i]   = a;
        req_funct3[i] = f3;
        req_wdata[i]  = wd;
        @(negedge clk);
        req_valid[i] = 1'b0;
        n      = 1;
        r_seen = 1'b0;
        r_lat  = -1;
        while (n <= 40 && !r_seen) begin
            if (rsp_valid[i]) begin
                r_seen   = 1'b1;
                r_lat    = n;
                r_rdata  = rsp_rdata[i];
                r_err    = rsp_err[i];
                r_wr     = wr[i];
                r_rd     = rd[i];
                r_addr   = addr[i];
                r_wdata  = wr_data[i];
                r_rddata = rd_data[i];
            end else begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 3'b000;
        req_valid = '0;
        req_we = '0;
        for (int i = 0; i < 3; i++) begin
            req_addr[i] = '0;
            req_funct3[i] = '0;
            req_wdata[i] = '0;
        end
        repeat (3) @(negedge clk);
        reset = 3'b111;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            compared++;
            if ({req_ready[i], rsp_valid[i], rsp_err[i], wr[i], rd[i]} !== 5'b10000) begin
                mismatched++;
                $display("[TB] FAIL reset_ctrl[%0d]: got %b expected 10000", i,
                         {req_ready[i], rsp_valid[i], rsp_err[i], wr[i], rd[i]});
            end
            compared++;
            if ({addr[i], wr_data[i], rd_data[i], rsp_rdata[i]} !== '0) begin
                mismatched++;
                $display("[TB] FAIL reset_data[%0d]: got %h/%h/%h/%h expected all 0", i,
                         addr[i], wr_data[i], rd_data[i], rsp_rdata[i]);
            end
        end
    endtask

    task automatic test_word_rw();
        access(0, 1'b1, 9'h010, 3'b010, 32'hDEADBEEF);
        compared++;
        if ({r_lat, r_err, r_wr, r_rd} !== {32'sd1, 3'b010}) begin
            mismatched++;
            $display("[TB] FAIL sw_resp: got lat=%0d err=%b wr=%b rd=%b expected lat=1 err=0 wr=1 rd=0",
                     r_lat, r_err, r_wr, r_rd);
        end
        compared++;
        if ({r_addr, r_wdata, r_rdata} !== {9'h010, 32'hDEADBEEF, 32'h0}) begin
            mismatched++;
            $display("[TB] FAIL sw_mon: got addr=%h wr_data=%h rdata=%h expected 010/deadbeef/0",
                     r_addr, r_wdata, r_rdata);
        end
        access(0, 1'b0, 9'h010, 3'b010, 32'h0);
        compared++;
        if ({r_lat, r_err, r_wr, r_rd} !== {32'sd1, 3'b001}) begin
            mismatched++;
            $display("[TB] FAIL lw_resp: got lat=%0d err=%b wr=%b rd=%b expected lat=1 err=0 wr=0 rd=1",
                     r_lat, r_err, r_wr, r_rd);
        end
        compared++;
        if ({r_rdata, r_rddata} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            mismatched++;
            $display("[TB] FAIL lw_data: got rdata=%h rd_data=%h expected deadbeef", r_rdata, r_rddata);
        end
    endtask

    task automatic test_lanes();
        logic [8:0]  la [5];
        logic [2:0]  lf [5];
        logic [31:0] le [5];
        la = '{9'h010, 9'h013, 9'h013, 9'h012, 9'h012};
        lf = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
        le = '{32'hDE7FBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDE7F, 32'h0000DE7F};
        access(0, 1'b1, 9'h012, 3'b000, 32'h1234567F);
        for (int k = 0; k < 5; k++) begin
            access(0, 1'b0, la[k], lf[k], 32'h0);
            compared++;
            if ({r_seen, r_err, r_rdata} !== {2'b10, le[k]}) begin
                mismatched++;
                $display("[TB] FAIL lane_load[%0d]: got seen=%b err=%b rdata=%h expected 1/0/%h",
                         k, r_seen, r_err, r_rdata, le[k]);
            end
        end
        access(0, 1'b1, 9'h030, 3'b010, 32'h11223344);
        access(0, 1'b1, 9'h032, 3'b001, 32'hFFFF8001);
        access(0, 1'b0, 9'h030, 3'b010, 32'h0);
        compared++;
        if (r_rdata !== 32'h80013344) begin
            mismatched++;
            $display("[TB] FAIL sh_merge: got %h expected 80013344", r_rdata);
        end
    endtask

    task automatic test_wait_states();
        logic [3:0] rdy_seq;
        logic [3:0] val_seq;
        logic [31:0] got_rdata;
        logic got_rd;
        access(1, 1'b1, 9'h040, 3'b010, 32'hA5A51234);
        compared++;
        if (r_lat !== 4) begin
            mismatched++;
            $display("[TB] FAIL ws3_sw_latency: got %0d expected 4", r_lat);
        end
        @(negedge clk);
        compared++;
        if (req_ready[1] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL ws3_ready_t: got %b expected 1", req_ready[1]);
        end
        req_valid[1]  = 1'b1;
        req_we[1]     = 1'b0;
        req_addr[1]   = 9'h040;
        req_funct3[1] = 3'b010;
        got_rdata = '0;
        got_rd = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rdy_seq[k] = req_ready[1];
            val_seq[k] = rsp_valid[1];
            if (rsp_valid[1]) begin
                got_rdata = rsp_rdata[1];
                got_rd = rd[1];
            end
            req_valid[1]  = 1'b0;
            req_we[1]     = 1'b1;
            req_addr[1]   = 9'h010;
            req_funct3[1] = 3'b111;
        end
        compared++;
        if ({rdy_seq, val_seq} !== 8'b0000_1000) begin
            mismatched++;
            $display("[TB] FAIL ws3_timing: got ready=%b valid=%b (bit k = cycle t+1+k) expected 0000/1000",
                     rdy_seq, val_seq);
        end
        compared++;
        if ({got_rd, got_rdata} !== {1'b1, 32'hA5A51234}) begin
            mismatched++;
            $display("[TB] FAIL ws3_data: got rd=%b rdata=%h expected 1/a5a51234", got_rd, got_rdata);
        end
        @(negedge clk);
        compared++;
        if ({req_ready[1], rsp_valid[1]} !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL ws3_ready_t5: got ready=%b valid=%b expected 1/0", req_ready[1], rsp_valid[1]);
        end
        req_we[1] = 1'b0;
    endtask

    task automatic test_errors();
        access(0, 1'b0, 9'h010, 3'b011, 32'h0);
        compared++;
        if ({r_seen, r_err, r_rd, r_wr, r_rdata} !== {4'b1100, 32'h0}) begin
            mismatched++;
            $display("[TB] FAIL bad_f3_load: got seen=%b err=%b rd=%b wr=%b rdata=%h expected 1/1/0/0/0",
                     r_seen, r_err, r_rd, r_wr, r_rdata);
        end
        access(0, 1'b1, 9'h010, 3'b100, 32'h00000055);
        compared++;
        if ({r_seen, r_err, r_wr} !== 3'b110) begin
            mismatched++;
            $display("[TB] FAIL bad_store: got seen=%b err=%b wr=%b expected 1/1/0", r_seen, r_err, r_wr);
        end
        access(0, 1'b0, 9'h010, 3'b010, 32'h0);
        compared++;
        if (r_rdata !== 32'hDE7FBEEF) begin
            mismatched++;
            $display("[TB] FAIL bad_store_mem: got %h expected de7fbeef", r_rdata);
        end
        access(0, 1'b0, 9'h011, 3'b010, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
        compared++;
        if ({r_seen, r_err, r_rd, r_rdata} !== {3'b110, 32'h0}) begin
            mismatched++;
            $display("[TB] FAIL misaligned_lw: got seen=%b err=%b rd=%b rdata=%h expected 1/1/0/0",
                     r_seen, r_err, r_rd, r_rdata);
        end
`else
        compared++;
        if ({r_seen, r_err, r_rdata, r_addr} !== {2'b10, 32'hDE7FBEEF, 9'h011}) begin
            mismatched++;
            $display("[TB] FAIL masked_lw: got seen=%b err=%b rdata=%h addr=%h expected 1/0/de7fbeef/011",
                     r_seen, r_err, r_rdata, r_addr);
        end
        access(0, 1'b0, 9'h013, 3'b001, 32'h0);
        compared++;
        if ({r_err, r_rdata} !== {1'b0, 32'hFFFFDE7F}) begin
            mismatched++;
            $display("[TB] FAIL masked_lh: got err=%b rdata=%h expected 0/ffffde7f", r_err, r_rdata);
        end
`endif
    endtask

    task automatic test_reset_mid_op();
        logic seen;
        access(2, 1'b1, 9'h020, 3'b010, 32'hCAFEF00D);
        compared++;
        if (r_lat !== 3) begin
            mismatched++;
            $display("[TB] FAIL ws2_latency: got %0d expected 3", r_lat);
        end
        @(negedge clk);
        req_valid[2]  = 1'b1;
        req_we[2]     = 1'b1;
        req_addr[2]   = 9'h020;
        req_funct3[2] = 3'b010;
        req_wdata[2]  = 32'h12345678;
        @(negedge clk);
        req_valid[2] = 1'b0;
        seen = rsp_valid[2];
        reset[2] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | rsp_valid[2];
        end
        reset[2] = 1'b1;
        @(negedge clk);
        compared++;
        if ({req_ready[2], rsp_valid[2], rsp_err[2], wr[2], rd[2]} !== 5'b10000) begin
            mismatched++;
            $display("[TB] FAIL midrst_ctrl: got %b expected 10000",
                     {req_ready[2], rsp_valid[2], rsp_err[2], wr[2], rd[2]});
        end
        compared++;
        if ({addr[2], wr_data[2], rd_data[2], rsp_rdata[2]} !== '0) begin
            mismatched++;
            $display("[TB] FAIL midrst_data: got %h/%h/%h/%h expected all 0",
                     addr[2], wr_data[2], rd_data[2], rsp_rdata[2]);
        end
        repeat (4) begin
            @(negedge clk);
            seen = seen | rsp_valid[2];
        end
        compared++;
        if (seen !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midrst_no_rsp: got rsp_valid seen=%b expected 0", seen);
        end
        access(2, 1'b0, 9'h020, 3'b010, 32'h0);
        compared++;
        if ({r_seen, r_rdata} !== {1'b1, 32'hCAFEF00D}) begin
            mismatched++;
            $display("[TB] FAIL midrst_mem: got seen=%b rdata=%h expected 1/cafef00d", r_seen, r_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_lanes();
        test_wait_states();
        test_errors();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
